multiplication_block: RTL
=========================

# multiplication_block

Sequential radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. It complements the division block in the execute stage's M-extension unit and uses the same operand and handshake conventions: `data_valid` starts an operation, `data_ready` reports completion, and `product_o` carries the XLEN-bit result. Operands are converted to magnitudes and multiplied unsigned over XLEN iterations. The 2·XLEN product is sign-corrected, then the low or high half is selected per `operation`.

## Interface
- `XLEN`, default 32: operand and result width.
- `COUNT_WIDTH`, default `$clog2(XLEN)`: iteration counter width.
- `CLK`  in  1  single clock; all state is updated on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `multiplicand`  in  XLEN  rs1 operand; sampled only on the accept edge.
- `multiplier`  in  XLEN  rs2 operand; sampled only on the accept edge.
- `data_valid`  in  1  start request; acted on only when the FSM is in IDLE.
- `operation`  in  2  00=MUL, 01=MULH, 10=MULHSU, 11=MULHU; sampled on the accept edge.
- `product_o`  out  XLEN  registered result; holds its value until the next completion.
- `data_ready`  out  1  registered; high for exactly one cycle when `product_o` updates.
- `busy`  out  1  registered; high while an operation is in flight (BUSY state).

## Operation
- FSM states: IDLE, BUSY, DONE. Reset places the FSM in IDLE.
- Sign flags:
  - `sa` = `multiplicand[XLEN-1]`, applied for MUL, MULH and MULHSU.
  - `sb` = `multiplier[XLEN-1]`, applied for MUL and MULH only.
  - MULHU treats both operands as unsigned.
- Magnitudes: each operand whose sign flag is set is two's-complement negated. `neg` = `sa ^ sb` is latched with the magnitudes and the op.
- Magnitude edge case: the most-negative value (0x80000000) gives magnitude 0x80000000. This is correct when interpreted unsigned and needs no special case.
- IDLE with `data_valid`=1:
  - Latch the magnitudes, `neg` and `operation`.
  - Clear the XLEN-bit accumulator `acc` and the counter.
  - Go to BUSY; `busy` rises.
- BUSY, once per cycle:
  - If `mplr[0]`, set {carry, acc} = acc + mcand (XLEN+1 bits).
  - Then shift {carry, acc, mplr} right by 1.
  - The counter increments. At count = XLEN-1 the iteration executes and the FSM goes to DONE.
- DONE (one cycle):
  - Form P = {acc, mplr}, a 2·XLEN unsigned magnitude; if `neg`, P = ~P + 1.
  - `product_o` = P[XLEN-1:0] for MUL, otherwise P[2XLEN-1:XLEN].
  - Register `product_o`, pulse `data_ready`, drop `busy`, return to IDLE.
- `data_valid` asserted in BUSY or DONE is ignored; there is no queueing. The requester must hold or re-issue it.
- Latency is fixed; there is no early termination for zero or small operands.
- The `operation` encodings cover all four values, so there is no default or illegal case.

## Timing
- Reset values: `product_o`=0, `data_ready`=0, `busy`=0, FSM=IDLE, all internal registers 0.
- Accept at edge E0. `busy`=1 from E0 to E(XLEN+1).
- `data_ready`=1 and the new `product_o` take effect from edge E(XLEN+1). `data_ready` falls at E(XLEN+2).
  - Latency: XLEN+1 cycles, which is 33 for XLEN=32.
- Back-to-back: the FSM is in IDLE during the `data_ready` cycle, so a `data_valid` sampled then is accepted. Issue interval is XLEN+1 cycles.
- Operands may change freely after E0; the block does not read them again.
- Reset asserted mid-operation:
  - All outputs and state clear immediately (asynchronously).
  - The in-flight result is discarded; no `data_ready` pulse.
  - After deassertion the FSM is in IDLE and accepts on the next valid edge.
- `product_o` stays stable between completions regardless of the inputs.

## Test plan
- Reset, then MUL 7 × 6:
  - `data_ready` exactly 33 cycles after accept, lasting 1 cycle.
  - `product_o`=0x0000002A.
  - `busy` high for 33 cycles.
- Signed corners, one operation each:
  - MUL 0xFFFFFFFD × 0x00000005 → 0xFFFFFFF1.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000.
- Mixed and unsigned, one operation each:
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHU 0 × 0x12345678 → 0 with the full 33-cycle latency.
- Busy-time input changes:
  - Hold `data_valid`=1 and change operands and `operation` while BUSY.
  - Required: the first result reflects only the E0 values.
  - Required: a second op is accepted in the `data_ready` cycle, completing 33 cycles later.
- Reset mid-operation:
  - Assert `rst_n`=0 at cycle 10 of an operation.
  - Required: outputs 0 immediately and no `data_ready` follows.
  - Required: a new MUL 3 × 4 after release returns 0x0000000C.
- Random regression: 10k random operands and ops compared against a 64-bit reference model. Also check that `data_ready` is never high for two consecutive cycles.

Source files
------------

// File: rtl/multiplication_block.sv
// Sequential radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes, multiplied over XLEN cycles, then sign-corrected.
module multiplication_block #(
  parameter int XLEN        = 32,
  parameter int COUNT_WIDTH = $clog2(XLEN)
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  input  logic            data_valid,
  input  logic [1:0]      operation,
  output logic [XLEN-1:0] product_o,
  output logic            data_ready,
  output logic            busy
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                 state, next_state;
  op_e                    op_q;
  logic                   neg;
  logic [XLEN-1:0]        mcand;
  logic [XLEN-1:0]        mplr;
  logic [XLEN-1:0]        acc;
  logic [COUNT_WIDTH-1:0] count;

  // Operand conditioning, evaluated on the raw inputs for the accept edge.
  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;

  // Per-iteration datapath and final result formation.
  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] p_mag;
  logic [2*XLEN-1:0] p_signed;
  logic [XLEN-1:0]   result;

  always_comb begin
    sa    = (operation != OP_MULHU) && multiplicand[XLEN-1];
    sb    = ((operation == OP_MUL) || (operation == OP_MULH)) && multiplier[XLEN-1];
    mag_a = sa ? (~multiplicand + 1'b1) : multiplicand;
    mag_b = sb ? (~multiplier + 1'b1) : multiplier;
  end

  always_comb begin
    addend   = mplr[0] ? mcand : '0;
    sum      = {1'b0, acc} + {1'b0, addend};
    p_mag    = {acc, mplr};
    p_signed = neg ? (~p_mag + 1'b1) : p_mag;
    result   = (op_q == OP_MUL) ? p_signed[XLEN-1:0] : p_signed[2*XLEN-1:XLEN];
  end

  // NOTE: next_state gets its default before the case, so every path assigns it
  // and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (data_valid) next_state = BUSY;
      BUSY:    if (count == COUNT_WIDTH'(XLEN - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_MUL;
      neg        <= 1'b0;
      mcand      <= '0;
      mplr       <= '0;
      acc        <= '0;
      count      <= '0;
      product_o  <= '0;
      data_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      data_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (data_valid) begin
            op_q  <= op_e'(operation);
            neg   <= sa ^ sb;
            mcand <= mag_a;
            mplr  <= mag_b;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          // Conditional add, then shift {carry, acc, mplr} right by one.
          acc   <= sum[XLEN:1];
          mplr  <= {sum[0], mplr[XLEN-1:1]};
          count <= count + 1'b1;
        end
        DONE: begin
          product_o  <= result;
          data_ready <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
